// File: rtl/mem_copy_engine_pkg.sv
// Shared constants for the memory copy engine: default widths, FSM state
// encoding and the index wrap modulus.
package mem_copy_engine_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 24;
    localparam int IDX_W_DEF  = 8;

    // Index arithmetic is done in IDX_W bits, so it wraps at this modulus.
    localparam int IDX_DEPTH = 1 << IDX_W_DEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word copy engine for a combinational-read memory: alternates RD and
// WR cycles in ascending index order, then pulses done from FIN.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  src,
    input  logic [IDX_W-1:0]  dst,
    input  logic [IDX_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        dbg_state_o
);

    // Handshake: start is sampled only while IDLE (busy=0); there is no ready.
    // busy rises the cycle after acceptance and falls after the done pulse.

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  idx;

    assign cnt_inc = cnt_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len != '0) ? ST_RD : ST_FIN;
                end
            end
            ST_RD: begin
                data_d  = mem_dout;
                state_d = ST_WR;
            end
            ST_WR: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? ST_FIN : ST_RD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode from state only, so async reset forces them to 0 at once.
    always_comb begin
        idx     = '0;
        mem_din = '0;
        mem_we  = 1'b0;
        case (state_q)
            ST_RD: idx = src_q + cnt_q;
            ST_WR: begin
                idx     = dst_q + cnt_q;
                mem_din = data_q;
                mem_we  = 1'b1;
            end
            default: idx = '0;
        endcase
    end

    assign mem_addr    = {{(ADDR_W-IDX_W){1'b0}}, idx};
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed table, hand-written
// corner sequences and randomized copies against a behavioural memory model.
module tb_mem_copy_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  src, dst, len;
  logic        busy, done, mem_we;
  logic [23:0] mem_addr, mem_din, mem_dout;
  logic [1:0]  dbg_state;

  logic [23:0] mem [256];
  logic [23:0] ref_mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [23:0] pl_data;

  int checks = 0;
  int errors = 0;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .dbg_state_o(dbg_state)
  );

  // clock / memory beside the DUT
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_dout = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  typedef struct {
    logic [7:0]       src;
    logic [7:0]       dst;
    logic [7:0]       len;
    int               exp_cyc;
    int               exp_wr;
    logic [7:0]       pre_base;
    int               pre_n;
    logic [0:3][23:0] pre_v;
    logic [7:0]       exp_base;
    int               exp_n;
    logic [0:3][23:0] exp_v;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mem_poke(input logic [7:0] a, input logic [23:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // reference: sequential ascending word copy with 8-bit index wrap
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] si, di;
    for (int i = 0; i < n; i++) begin
      si = s + 8'(i);
      di = d + 8'(i);
      ref_mem[di] = ref_mem[si];
    end
  endtask

  task automatic cmp_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // driver: starts a copy in an IDLE cycle and observes it to the done pulse
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit glitch, output int cyc, output int wr);
    int rd_k = 0;
    int seq_bad = 0;
    int busy_bad = 0;
    int fin_bad = 0;
    bit done_seen = 0;
    bit glitched = 0;
    logic [7:0] ea;
    @(negedge clk);
    check("idle_before", {dbg_state, busy, done, mem_we, (mem_addr == 24'd0), (mem_din == 24'd0)},
          {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
    cyc = 0;
    wr = 0;
    while (!done_seen && cyc < 2 * int'(l) + 20) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_bad++;
      if (mem_addr[23:8] != 16'd0) seq_bad++;
      if (done) begin
        done_seen = 1;
        if (mem_we || mem_addr != 24'd0 || mem_din != 24'd0) fin_bad++;
      end else if (mem_we) begin
        ea = d + 8'(wr);
        if (mem_addr[7:0] != ea) seq_bad++;
        wr++;
      end else begin
        ea = s + 8'(rd_k);
        if (mem_addr[7:0] != ea) seq_bad++;
        rd_k++;
      end
      if (glitch && mem_we && !glitched) begin
        glitched = 1;
        start = 1'b1; src = s + 8'd50; dst = d + 8'd77; len = l + 8'd4;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check("done_seen", done_seen, 1);
    check("busy_during", busy_bad, 0);
    check("fin_outputs", fin_bad, 0);
    check("addr_sequence", seq_bad, 0);
  endtask

  initial begin
    int cyc, wr;
    logic [7:0] a, s, d, l;
    int budget;

    rst = 1'b1; start = 1'b0; src = 8'd0; dst = 8'd0; len = 8'd0;
    pl_en = 1'b0; pl_addr = 8'd0; pl_data = 24'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {dbg_state, busy, done, mem_we, (mem_addr == 24'd0), (mem_din == 24'd0)},
          {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst = 1'b0;

    for (int i = 0; i < 256; i++) mem_poke(8'(i), 24'($urandom));

    tbl[0] = '{src:8'd0, dst:8'd10, len:8'd3, exp_cyc:7, exp_wr:3,
               pre_base:8'd0, pre_n:3, pre_v:{24'h000011, 24'h000022, 24'h000033, 24'h0},
               exp_base:8'd10, exp_n:3, exp_v:{24'h000011, 24'h000022, 24'h000033, 24'h0}};
    tbl[1] = '{src:8'd5, dst:8'd20, len:8'd0, exp_cyc:1, exp_wr:0,
               pre_base:8'd0, pre_n:0, pre_v:{4{24'h0}},
               exp_base:8'd0, exp_n:0, exp_v:{4{24'h0}}};
    tbl[2] = '{src:8'd254, dst:8'd100, len:8'd4, exp_cyc:9, exp_wr:4,
               pre_base:8'd254, pre_n:4, pre_v:{24'hA1A1A1, 24'hB2B2B2, 24'hC3C3C3, 24'hD4D4D4},
               exp_base:8'd100, exp_n:4, exp_v:{24'hA1A1A1, 24'hB2B2B2, 24'hC3C3C3, 24'hD4D4D4}};
    tbl[3] = '{src:8'd0, dst:8'd1, len:8'd3, exp_cyc:7, exp_wr:3,
               pre_base:8'd0, pre_n:4, pre_v:{24'd1, 24'd2, 24'd3, 24'd4},
               exp_base:8'd0, exp_n:4, exp_v:{24'd1, 24'd1, 24'd1, 24'd1}};
    tbl[4] = '{src:8'd200, dst:8'd250, len:8'd10, exp_cyc:21, exp_wr:10,
               pre_base:8'd0, pre_n:0, pre_v:{4{24'h0}},
               exp_base:8'd0, exp_n:0, exp_v:{4{24'h0}}};

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < tbl[t].pre_n; k++) begin
        a = tbl[t].pre_base + 8'(k);
        mem_poke(a, tbl[t].pre_v[k]);
      end
      run_copy(tbl[t].src, tbl[t].dst, tbl[t].len, 1'b0, cyc, wr);
      check($sformatf("tbl%0d_cycles", t), cyc, tbl[t].exp_cyc);
      check($sformatf("tbl%0d_writes", t), wr, tbl[t].exp_wr);
      model_copy(tbl[t].src, tbl[t].dst, int'(tbl[t].len));
      cmp_mem($sformatf("tbl%0d_memory", t));
      for (int k = 0; k < tbl[t].exp_n; k++) begin
        a = tbl[t].exp_base + 8'(k);
        check($sformatf("tbl%0d_word%0d", t, k), mem[a], tbl[t].exp_v[k]);
      end
    end

    // start pulsed during WR with other operands must be ignored
    for (int k = 0; k < 3; k++) mem_poke(8'(k), 24'h000011 * 24'(k + 1));
    run_copy(8'd0, 8'd10, 8'd3, 1'b1, cyc, wr);
    check("glitch_cycles", cyc, 7);
    check("glitch_writes", wr, 3);
    model_copy(8'd0, 8'd10, 3);
    cmp_mem("glitch_memory");

    // reset after two writes of a len=5 copy
    @(negedge clk);
    start = 1'b1; src = 8'd30; dst = 8'd130; len = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wr = 0;
    budget = 0;
    while (wr < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
      if (mem_we) wr++;
    end
    check("abort_reached_two_writes", wr, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_async_outputs", {dbg_state, busy, done, mem_we, (mem_addr == 24'd0), (mem_din == 24'd0)},
          {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    budget = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || mem_we) budget++;
    end
    check("abort_no_done", budget, 0);
    rst = 1'b0;
    model_copy(8'd30, 8'd130, 2);
    cmp_mem("abort_memory");

    run_copy(8'd40, 8'd140, 8'd5, 1'b0, cyc, wr);
    check("post_abort_cycles", cyc, 11);
    model_copy(8'd40, 8'd140, 5);
    cmp_mem("post_abort_memory");

    // randomized copies against the reference memory
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) mem_poke(8'($urandom), 24'($urandom));
      s = 8'($urandom);
      d = 8'($urandom);
      l = 8'($urandom_range(0, 40));
      run_copy(s, d, l, 1'b0, cyc, wr);
      check($sformatf("rand%0d_cycles", r), cyc, 2 * int'(l) + 1);
      check($sformatf("rand%0d_writes", r), wr, int'(l));
      model_copy(s, d, int'(l));
      cmp_mem($sformatf("rand%0d_memory", r));
    end

    // one long copy near the top of the length range
    run_copy(8'd17, 8'd90, 8'd255, 1'b0, cyc, wr);
    check("long_cycles", cyc, 511);
    model_copy(8'd17, 8'd90, 255);
    cmp_mem("long_memory");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
